// File: rtl/mixer_ctrl_pkg.sv
// Shared types and helpers for the mixer level controller and its neighbours.
// level_t is the width of the mixer gain-table index.
package mixer_ctrl_pkg;

  typedef logic [6:0] level_t;

  localparam int MAX_LEVEL_DEF = 82;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ctrl_state_t;

  function automatic level_t clamp_level(input level_t v, input level_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/mixer_level_ctrl_if.sv
// Control-plane bundle of the mixer level controller: host handshake, panel
// buttons, mute, and the applied/target level status.
interface mixer_level_ctrl_if;

  logic                   host_req;
  mixer_ctrl_pkg::level_t host_level;
  logic                   host_ack;
  logic                   btn_up;
  logic                   btn_down;
  logic                   mute;
  mixer_ctrl_pkg::level_t level;
  mixer_ctrl_pkg::level_t target;
  logic                   ramping;
  logic                   silent;

  modport ctrl (
    input  host_req, host_level, btn_up, btn_down, mute,
    output host_ack, level, target, ramping, silent
  );

  modport host (
    output host_req, host_level, btn_up, btn_down, mute,
    input  host_ack, level, target, ramping, silent
  );

endinterface

// File: rtl/lrclk_frame_edge.sv
// Brings lrclk into the clk domain and flags the start of each frame
// (falling edge = start of left word), two clocks after the lrclk edge.
module lrclk_frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  output logic fb
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  // p0: metastability stage, p1: synchronized sample, p2: history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= lrclk;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign fb = hist_p2 & ~sync_p1;

endmodule

// File: rtl/mixer_level_ctrl.sv
// Arbitrates host/button level requests and ramps the mixer level one step at
// a time, only on lrclk frame boundaries, so the gain never changes mid-word.
module mixer_level_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int MAX_LEVEL       = MAX_LEVEL_DEF,
  parameter int INIT_LEVEL      = 41,
  parameter int FRAMES_PER_STEP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  mixer_level_ctrl_if.ctrl ctl
);

  localparam level_t     MAX_L    = level_t'(MAX_LEVEL);
  localparam level_t     INIT_L   = level_t'(INIT_LEVEL);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  function automatic level_t sat_inc(input level_t v);
    return (v >= MAX_L) ? MAX_L : level_t'(v + 7'd1);
  endfunction

  function automatic level_t sat_dec(input level_t v);
    return (v == '0) ? '0 : level_t'(v - 7'd1);
  endfunction

  // Only called while cur != dst, so the result never overshoots.
  function automatic level_t step_toward(input level_t cur, input level_t dst);
    return (dst > cur) ? level_t'(cur + 7'd1) : level_t'(cur - 7'd1);
  endfunction

  logic        fb;
  level_t      target_p0;
  level_t      level_p0;
  logic        host_ack_p0;
  logic        ramping_p0;
  logic        silent_p0;
  ctrl_state_t state;
  logic [7:0]  frame_cnt;

  level_t eff;
  level_t level_nxt;
  logic   host_take;

  lrclk_frame_edge u_frame_edge (
    .clk   (clk),
    .rst   (rst),
    .lrclk (lrclk),
    .fb    (fb)
  );

  always_comb begin
    host_take = ctl.host_req & ~host_ack_p0;
    eff       = ctl.mute ? '0 : target_p0;
    level_nxt = step_toward(level_p0, eff);
  end

  // Target register: host wins; buttons in the same cycle are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      target_p0   <= INIT_L;
      host_ack_p0 <= 1'b0;
    end else begin
      host_ack_p0 <= host_take;
      if (host_take)
        target_p0 <= clamp_level(ctl.host_level, MAX_L);
      else if (ctl.btn_up && !ctl.btn_down)
        target_p0 <= sat_inc(target_p0);
      else if (ctl.btn_down && !ctl.btn_up)
        target_p0 <= sat_dec(target_p0);
    end
  end

  // Ramp FSM: the frame counter survives a mid-ramp change of eff
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      level_p0   <= INIT_L;
      frame_cnt  <= '0;
      ramping_p0 <= 1'b0;
      silent_p0  <= 1'b0;
    end else begin
      silent_p0 <= ctl.mute && (level_p0 == '0) && (state == IDLE);
      case (state)
        IDLE: begin
          if (level_p0 != eff) begin
            state      <= RAMP;
            ramping_p0 <= 1'b1;
            frame_cnt  <= '0;
          end
        end
        RAMP: begin
          if (level_p0 == eff) begin
            state      <= IDLE;
            ramping_p0 <= 1'b0;
          end else if (fb) begin
            if (frame_cnt == CNT_LAST) begin
              level_p0  <= level_nxt;
              frame_cnt <= '0;
              if (level_nxt == eff) begin
                state      <= IDLE;
                ramping_p0 <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.host_ack = host_ack_p0;
  assign ctl.level    = level_p0;
  assign ctl.target   = target_p0;
  assign ctl.ramping  = ramping_p0;
  assign ctl.silent   = silent_p0;

endmodule

// File: tb/tb_mixer_level_ctrl.sv
// Directed bench for mixer_level_ctrl: default-parameter instance (a) and a
// one-frame-per-step instance (b) sharing clk, rst and lrclk.
module tb_mixer_level_ctrl;
  import mixer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lr_base = 1'b0;
  logic lr_dip = 1'b0;
  logic lrclk;

  assign lrclk = lr_base & ~lr_dip;

  mixer_level_ctrl_if ia ();
  mixer_level_ctrl_if ib ();

  mixer_level_ctrl u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .lrclk (lrclk),
    .ctl   (ia.ctrl)
  );

  mixer_level_ctrl #(
    .FRAMES_PER_STEP (1)
  ) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .lrclk (lrclk),
    .ctl   (ib.ctrl)
  );

  // 10 ns clk; 80 ns frame, lrclk edges on clk falling edges
  initial forever #5 clk = ~clk;
  initial forever #40 lr_base = ~lr_base;

  int tests = 0;
  int fails = 0;
  int viol_a = 0;
  int viol_b = 0;

  typedef struct {
    logic   host;
    level_t hlvl;
    logic   up;
    logic   dn;
    level_t exp_tgt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic host_a(input level_t v);
    @(negedge clk);
    ia.host_req = 1'b1; ia.host_level = v;
    @(negedge clk);
    ia.host_req = 1'b0;
  endtask

  task automatic host_b(input level_t v);
    @(negedge clk);
    ib.host_req = 1'b1; ib.host_level = v;
    @(negedge clk);
    ib.host_req = 1'b0;
  endtask

  task automatic wait_lvl_a(input level_t v, input int budget, input string nm);
    int n = 0;
    while (ia.level !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(ia.level), int'(v));
  endtask

  task automatic wait_lvl_b(input level_t v, input int budget, input string nm);
    int n = 0;
    while (ib.level !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(ib.level), int'(v));
  endtask

  // Waits for the next lrclk fall, then to the clk after the level update.
  task automatic after_fall();
    @(negedge lr_base);
    #1;
    repeat (3) @(negedge clk);
  endtask

  // Level may change only in the cycle right after a frame boundary
  initial begin
    logic s0, s1, h, fb_pre, rst_pre;
    level_t pa, pb;
    int mask;
    s0 = 1'b0; s1 = 1'b0; h = 1'b0; pa = '0; pb = '0; mask = 8;
    forever begin
      @(posedge clk);
      fb_pre  = h & ~s1;
      rst_pre = rst;
      h  = s1;
      s1 = s0;
      s0 = lrclk;
      #1;
      if (rst_pre) mask = 4;
      else if (mask > 0) mask--;
      else begin
        if (ia.level !== pa && !fb_pre) viol_a++;
        if (ib.level !== pb && !fb_pre) viol_b++;
      end
      pa = ia.level;
      pb = ib.level;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 7'd120, 1'b0, 1'b0, 7'd82};
    vecs[1]  = '{1'b0, 7'd0,   1'b1, 1'b0, 7'd82};
    vecs[2]  = '{1'b1, 7'd1,   1'b0, 1'b0, 7'd1};
    vecs[3]  = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd0};
    vecs[4]  = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd0};
    vecs[5]  = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd0};
    vecs[6]  = '{1'b1, 7'd41,  1'b0, 1'b0, 7'd41};
    vecs[7]  = '{1'b1, 7'd10,  1'b1, 1'b0, 7'd10};
    vecs[8]  = '{1'b0, 7'd0,   1'b1, 1'b0, 7'd11};
    vecs[9]  = '{1'b0, 7'd0,   1'b1, 1'b1, 7'd11};
    vecs[10] = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd10};
    vecs[11] = '{1'b1, 7'd82,  1'b0, 1'b0, 7'd82};
    vecs[12] = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd81};
    vecs[13] = '{1'b1, 7'd0,   1'b0, 1'b1, 7'd0};
    vecs[14] = '{1'b0, 7'd0,   1'b1, 1'b0, 7'd1};

    ia.host_req = 1'b0; ia.host_level = '0; ia.btn_up = 1'b0; ia.btn_down = 1'b0; ia.mute = 1'b0;
    ib.host_req = 1'b0; ib.host_level = '0; ib.btn_up = 1'b0; ib.btn_down = 1'b0; ib.mute = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_level", int'(ia.level), 41);
    check("rst_target", int'(ia.target), 41);
    check("rst_ramping", int'(ia.ramping), 0);
    check("rst_silent", int'(ia.silent), 0);
    check("rst_ack", int'(ia.host_ack), 0);
    rst = 1'b0;

    repeat (800) @(negedge clk);
    check("idle100_level", int'(ia.level), 41);
    check("idle100_target", int'(ia.target), 41);
    check("idle100_ramping", int'(ia.ramping), 0);

    // Host request to 44: one ack pulse, one step every 16 frame boundaries
    @(posedge lr_base);
    #1;
    @(negedge clk);
    ia.host_req = 1'b1; ia.host_level = 7'd44;
    @(negedge clk);
    ia.host_req = 1'b0;
    check("h44_ack", int'(ia.host_ack), 1);
    check("h44_target", int'(ia.target), 44);
    @(negedge clk);
    check("h44_ack_drop", int'(ia.host_ack), 0);
    check("h44_ramping", int'(ia.ramping), 1);
    for (int k = 1; k <= 48; k++) begin
      after_fall();
      if (k == 15 || k == 16 || k == 31 || k == 32 || k == 47 || k == 48)
        check($sformatf("h44_level_fb%0d", k), int'(ia.level), 41 + k / 16);
    end
    check("h44_ramping_done", int'(ia.ramping), 0);

    // Target arbitration table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ia.host_req = vecs[i].host; ia.host_level = vecs[i].hlvl;
      ia.btn_up = vecs[i].up; ia.btn_down = vecs[i].dn;
      @(negedge clk);
      ia.host_req = 1'b0; ia.btn_up = 1'b0; ia.btn_down = 1'b0;
      check($sformatf("vec%0d_target", i), int'(ia.target), int'(vecs[i].exp_tgt));
      check($sformatf("vec%0d_ack", i), int'(ia.host_ack), int'(vecs[i].host));
      @(negedge clk);
      check($sformatf("vec%0d_ack_drop", i), int'(ia.host_ack), 0);
    end

    // Held request after ack is taken again on the following cycle
    @(negedge clk);
    ia.host_req = 1'b1; ia.host_level = 7'd30;
    @(negedge clk);
    check("held_ack1", int'(ia.host_ack), 1);
    ia.host_level = 7'd31;
    @(negedge clk);
    check("held_ack_gap", int'(ia.host_ack), 0);
    @(negedge clk);
    ia.host_req = 1'b0;
    check("held_ack2", int'(ia.host_ack), 1);
    check("held_target", int'(ia.target), 31);

    // Reset in the middle of a ramp from 41 toward 60
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    host_a(7'd60);
    wait_lvl_a(7'd50, 2500, "mid_reach50");
    check("mid_ramping", int'(ia.ramping), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_level", int'(ia.level), 41);
    check("mid_rst_target", int'(ia.target), 41);
    check("mid_rst_ramping", int'(ia.ramping), 0);
    repeat (320) @(negedge clk);
    check("mid_rst_hold_level", int'(ia.level), 41);

    // Mute ramp on the one-frame-per-step instance
    host_b(7'd3);
    wait_lvl_b(7'd3, 800, "mute_reach3");
    @(posedge lr_base);
    #1;
    @(negedge clk);
    ib.mute = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      after_fall();
      check($sformatf("mute_level_fb%0d", k), int'(ib.level), 3 - k);
    end
    check("mute_silent_early", int'(ib.silent), 0);
    @(negedge clk);
    check("mute_silent", int'(ib.silent), 1);
    check("mute_target", int'(ib.target), 3);
    ib.mute = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      after_fall();
      check($sformatf("unmute_level_fb%0d", k), int'(ib.level), k);
    end
    check("unmute_silent", int'(ib.silent), 0);
    check("unmute_ramping", int'(ib.ramping), 0);

    // Short lrclk dips inside the high half of the frame
    host_b(7'd20);
    repeat (6) begin
      @(posedge lr_base);
      #1;
      repeat (2) @(negedge clk);
      lr_dip = 1'b1;
      @(negedge clk);
      lr_dip = 1'b0;
    end
    check("dip_progress", int'(ib.level > 7'd3), 1);
    wait_lvl_b(7'd20, 800, "dip_reach20");

    repeat (4) @(negedge clk);
    check("level_only_on_fb_a", viol_a, 0);
    check("level_only_on_fb_b", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mixer_level_ctrl.md
Name: mixer_level_ctrl

Overview:
- Sequences the 7-bit `level` input of the bit-serial mixer.
- Arbitrates level requests from two requesters:
  - host: set-absolute, with req/ack handshake;
  - front-panel buttons: single-cycle up/down pulses.
- Ramps the applied level one step at a time, changing it only at an lrclk frame boundary. This avoids zipper noise and a table change mid-word.
- Sits between the control plane and the mixer `level` port, in the clk domain, sampling lrclk like the serial datapath does.

Parameters:
- MAX_LEVEL, 82: highest valid mixer level; all targets are clamped to it.
- INIT_LEVEL, 41: level and target value after reset.
- FRAMES_PER_STEP, 16: frame boundaries per one-step level change (range 1..256).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- lrclk  input  1  I2S word clock, sampled in clk domain
- host_req  input  1  host level request, held until host_ack
- host_level  input  7  requested absolute level, valid with host_req
- host_ack  output  1  one-cycle pulse: request accepted
- btn_up  input  1  one-cycle pulse: target +1
- btn_down  input  1  one-cycle pulse: target -1
- mute  input  1  level-sensitive mute request
- level  output  7  applied level to mixer
- target  output  7  stored (unmuted) target
- ramping  output  1  high while level != effective target
- silent  output  1  high when muted and level has reached 0

Behaviour:
- Reset (rst sampled high on clk):
  - level = target = INIT_LEVEL; host_ack = 0; ramping = 0; silent = 0.
  - Frame counter = 0; lrclk history register = 0; state = IDLE.
  - Reset mid-ramp abandons the ramp with no further level change.
- Frame boundary (fb):
  - fb = 1 for one clk when the registered lrclk was 1 and the current sample is 0 (falling edge = start of left word).
  - Two-stage lrclk sampling (synchronizer + history register) is used; fb latency is 2 clk from the lrclk edge.
- Target update, evaluated every clk:
  - Priority order: host > btn_up > btn_down.
  - Host accepted when host_req = 1 and host_ack was 0 last cycle:
    - target <= min(host_level, MAX_LEVEL);
    - host_ack = 1 in the next cycle only.
    - Buttons asserted in the same cycle are dropped, not queued.
  - btn_up: target <= target + 1, saturating at MAX_LEVEL.
  - btn_down: target <= target - 1, saturating at 0.
  - btn_up and btn_down together with no host request: no change.
  - The host must drop host_req after host_ack; a req still held after ack is accepted again the following cycle. This is legal, not an error.
- Effective target eff = mute ? 0 : target. target is preserved through mute.
- FSM:
  - IDLE (level == eff, ramping = 0): go to RAMP when level != eff. The frame counter is cleared on entry to RAMP.
  - RAMP (ramping = 1): on each fb, the counter increments.
    - When the counter == FRAMES_PER_STEP-1 and fb: level moves 1 toward eff, counter <= 0.
    - If level then equals eff: go to IDLE.
    - If eff changes mid-ramp: direction re-evaluates immediately; the counter is not cleared.
    - If eff becomes equal to level before a step: go to IDLE with no step.
- Level changes on fb cycles only; the mixer's `level` never changes inside a frame.
- silent = mute && level == 0 && state == IDLE, registered (1 clk after the condition).
- Output timing: all outputs are registered. level changes in the cycle after the fb that triggers it.
- Step latency: a ±1 target change from IDLE reaches `level` after exactly FRAMES_PER_STEP frame boundaries.
- FRAMES_PER_STEP = 1: level steps on every fb.

Decomposition:
- Package mixer_ctrl_pkg:
  - level_t (logic [6:0]);
  - MAX_LEVEL_DEF = 82;
  - enum ctrl_state_t {IDLE, RAMP};
  - function clamp_level.
- One sub-module, lrclk_frame_edge: synchronizer plus falling-edge detector producing fb. It is reusable by other serial blocks.
- Arbitration, target register and FSM stay in mixer_level_ctrl.

Test Plan:
- Reset with default parameters and no activity → level = 41, target = 41, ramping = 0, silent = 0; no change over 100 frames.
- host_req with host_level = 44 → host_ack is a single pulse 1 clk later; target = 44; level hits 42, 43, 44 after exactly 16, 32 and 48 fb; then ramping = 0.
- host_level = 120 → target = 82 (clamped). btn_up at target 82 → target stays 82. btn_down ×3 from target 1 → target = 0.
- host_req together with btn_up in the same cycle, target 41 and host_level 10 → target = 10; the button is ignored.
- mute = 1 with level 3 and FRAMES_PER_STEP = 1 → level 2, 1, 0 on successive fb; silent = 1 one clk after reaching 0; target stays 3. mute = 0 → level ramps back to 3; silent = 0.
- rst asserted mid-ramp with level 50 and target 60 → next cycle level = 41, target = 41, state IDLE, counter 0. Also check: an lrclk toggling only in the middle of a frame never changes level off an fb cycle.
